// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache.
// Read misses refill a whole line over a req/ack handshake, fetching words in
// order 0..WORDS-1. Stores always write through to backing memory.
// Optional macro DCACHE_STATS_EN enables the read hit/miss counters; when it is
// undefined, stat_hits/stat_misses are tied to zero.
module dcache_dm #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 16,
    parameter int WORDS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int WA_W  = ADDR_W - 2;
    localparam int TAG_W = WA_W - IDX_W - OFF_W;

    typedef enum logic [2:0] {IDLE, COMPARE, REFILL, WRITE_MEM, DONE} state_t;

    state_t            state_q, state_d;
    logic [WA_W-1:0]   waddr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [OFF_W-1:0]  cnt_q;
    logic              gap_q;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES*WORDS];

    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic [OFF_W-1:0]  off_q;
    logic              hit;
    logic              beat_ack;
    logic              last_beat;
    logic              addr_lsb_unused;

    assign tag_q     = waddr_q[WA_W-1 -: TAG_W];
    assign idx_q     = waddr_q[OFF_W +: IDX_W];
    assign off_q     = waddr_q[OFF_W-1:0];
    assign hit       = valid_q[idx_q] && (tag_mem[idx_q] == tag_q);
    assign beat_ack  = (state_q == REFILL) && !gap_q && mem_ack;
    assign last_beat = (cnt_q == OFF_W'(WORDS - 1));
    // Byte lane bits of the core address carry no meaning for word accesses.
    assign addr_lsb_unused = ^cpu_addr[1:0];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        cpu_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req) state_d = COMPARE;
            end
            COMPARE: begin
                if (we_q)     state_d = WRITE_MEM;
                else if (hit) state_d = DONE;
                else          state_d = REFILL;
            end
            REFILL: begin
                // The gap cycle after each beat keeps mem_req low for one cycle.
                mem_req  = !gap_q;
                mem_addr = {tag_q, idx_q, cnt_q, 2'b00};
                if (beat_ack && last_beat) state_d = DONE;
            end
            WRITE_MEM: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {waddr_q, 2'b00};
                mem_wdata = wdata_q;
                if (mem_ack) state_d = DONE;
            end
            DONE: begin
                cpu_ready = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, refill sequencing, valid bits and load data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waddr_q   <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            gap_q     <= 1'b0;
            valid_q   <= '0;
            cpu_rdata <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        waddr_q <= cpu_addr[ADDR_W-1:2];
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                    end
                end
                COMPARE: begin
                    if (!we_q) begin
                        if (hit) begin
                            cpu_rdata <= data_mem[{idx_q, off_q}];
                        end else begin
                            cnt_q <= '0;
                            gap_q <= 1'b0;
                        end
                    end
                end
                REFILL: begin
                    if (gap_q) begin
                        gap_q <= 1'b0;
                    end else if (mem_ack) begin
                        if (cnt_q == off_q) cpu_rdata <= mem_rdata;
                        if (last_beat) begin
                            valid_q[idx_q] <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            gap_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage: store-hit update and refill beats; tag written on the last beat.
    always_ff @(posedge clk) begin
        if (state_q == COMPARE && we_q && hit) begin
            data_mem[{idx_q, off_q}] <= wdata_q;
        end else if (beat_ack) begin
            data_mem[{idx_q, cnt_q}] <= mem_rdata;
            if (last_beat) tag_mem[idx_q] <= tag_q;
        end
    end

`ifdef DCACHE_STATS_EN
    // Load hit/miss counters, evaluated once per load in COMPARE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state_q == COMPARE && !we_q) begin
            if (hit) stat_hits   <= stat_hits + 32'd1;
            else     stat_misses <= stat_misses + 32'd1;
        end
    end
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: self-checking bench for dcache_dm. A transaction-level model
// (line valid/tag table plus a flat word memory) predicts hit/miss, load data,
// backing-memory traffic and statistics counters.
module tb_dcache_dm;

    localparam int LINES  = 16;
    localparam int WORDS  = 4;
    localparam int OFF_SH = 2;
    localparam int IDX_SH = 2 + $clog2(WORDS);
    localparam int TAG_SH = IDX_SH + $clog2(LINES);

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [31:0] stat_hits, stat_misses;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // environment memory (behind the DUT) and model memory (expected contents)
    logic [31:0] bmem    [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    logic        mvalid  [LINES];
    int unsigned mtag    [LINES];
    int unsigned m_hits, m_misses;

    logic [31:0] obs_addr[$];
    logic        obs_we[$];
    logic [31:0] obs_wdata[$];
    int unsigned mem_lat = 1;
    logic        spur_en = 1'b0;

    dcache_dm #(.ADDR_W(32), .DATA_W(32), .LINES(LINES), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        if (a >= 32'h100 && a <= 32'h10C) return 32'hA0 + ((a - 32'h100) >> 2);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    function automatic logic [31:0] bmem_rd(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return init_val(a);
    endfunction

    // Backing-memory responder: ack after mem_lat idle cycles, optional stray acks.
    initial begin : responder
        int unsigned wcnt;
        logic busy;
        wcnt = 0;
        busy = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mem_ack = 1'b0;
                busy = 1'b0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = mem_lat;
                end
                if (wcnt == 0) begin
                    busy = 1'b0;
                    mem_ack = 1'b1;
                    obs_addr.push_back(mem_addr);
                    obs_we.push_back(mem_we);
                    obs_wdata.push_back(mem_wdata);
                    if (mem_we) bmem[mem_addr] = mem_wdata;
                    else        mem_rdata = bmem_rd(mem_addr);
                end else begin
                    wcnt--;
                end
            end else begin
                busy = 1'b0;
                if (spur_en && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
            end
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
    endfunction

    task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
        check_eq({tag, "_hits"}, stat_hits, m_hits);
        check_eq({tag, "_misses"}, stat_misses, m_misses);
`else
        check_eq({tag, "_hits"}, stat_hits, 32'd0);
        check_eq({tag, "_misses"}, stat_misses, 32'd0);
`endif
    endtask

    // One core access, checked against the model; rd returns the load data seen.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd);
        int unsigned idx, tag, cyc;
        logic [31:0] waddr, base;
        logic hit_exp, done;
        idx   = (addr >> IDX_SH) % LINES;
        tag   = addr >> TAG_SH;
        waddr = addr & ~32'h3;
        base  = addr & ~(32'(WORDS * 4) - 32'd1);
        hit_exp = mvalid[idx] && (mtag[idx] == tag);
        obs_addr.delete();
        obs_we.delete();
        obs_wdata.delete();
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = wd;
        cyc = 0;
        done = 1'b0;
        while (cyc < 400 && !done) begin
            @(negedge clk);
            cyc++;
            if (cpu_ready) done = 1'b1;
        end
        rd = cpu_rdata;
        cpu_req = 1'b0;
        if (!done) begin
            check_eq("ready_timeout", {31'b0, cpu_ready}, 32'd1);
            return;
        end
        if (we) begin
            check_eq("st_beats", obs_addr.size(), 1);
            if (obs_addr.size() == 1) begin
                check_eq("st_we", {31'b0, obs_we[0]}, 32'd1);
                check_eq("st_addr", obs_addr[0], waddr);
                check_eq("st_wdata", obs_wdata[0], wd);
            end
            ref_mem[waddr] = wd;
        end else begin
            check_eq("ld_rdata", rd, ref_rd(waddr));
            if (hit_exp) begin
                check_eq("hit_beats", obs_addr.size(), 0);
                check_eq("hit_latency", cyc, 2);
                m_hits++;
            end else begin
                check_eq("rf_beats", obs_addr.size(), WORDS);
                for (int i = 0; i < obs_addr.size() && i < WORDS; i++) begin
                    check_eq("rf_addr", obs_addr[i], base + 32'(i * 4));
                    check_eq("rf_we", {31'b0, obs_we[i]}, 32'd0);
                end
                mvalid[idx] = 1'b1;
                mtag[idx] = tag;
                m_misses++;
            end
        end
        check_stats("stat");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] rd, a;
        int unsigned wait_cyc;
        rst = 1'b0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'b0, cpu_ready}, 32'd0);
        check_eq("rst_rdata", cpu_rdata, 32'd0);
        check_eq("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_stats("rst_stat");
        rst = 1'b1;

        // directed sequence
        mem_lat = 1;
        access(1'b0, 32'h104, '0, rd);
        check_eq("tp1_rdata", rd, 32'hA1);
        access(1'b0, 32'h10C, '0, rd);
        check_eq("tp2_rdata", rd, 32'hA3);
        mem_lat = 3;
        access(1'b1, 32'h108, 32'hDEADBEEF, rd);
        access(1'b0, 32'h108, '0, rd);
        check_eq("tp3_rdata", rd, 32'hDEADBEEF);
        mem_lat = 1;
        access(1'b1, 32'h900, 32'h12345678, rd);
        access(1'b0, 32'h900, '0, rd);
        check_eq("tp4_rdata", rd, 32'h12345678);
        access(1'b0, 32'h1104, '0, rd);
        access(1'b0, 32'h104, '0, rd);

        // reset during the third refill beat of a fresh line
        mem_lat = 2;
        obs_addr.delete();
        obs_we.delete();
        obs_wdata.delete();
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 32'h234;
        wait_cyc = 0;
        while (wait_cyc < 200 && !(obs_addr.size() == 2 && mem_req)) begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end
        check_eq("mid_rf_req", {31'b0, mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
        check_eq("mid_rst_mem_addr", mem_addr, 32'd0);
        check_eq("mid_rst_ready", {31'b0, cpu_ready}, 32'd0);
        check_eq("mid_rst_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        cpu_req = 1'b0;
        model_reset();
        check_stats("mid_rst_stat");
        @(negedge clk);
        rst = 1'b1;
        access(1'b0, 32'h234, '0, rd);
        access(1'b0, 32'h104, '0, rd);

        // randomized phase
        spur_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            mem_lat = $urandom_range(0, 3);
            a = (32'($urandom_range(0, 2)) << TAG_SH)
              | (32'($urandom_range(0, 7)) << IDX_SH)
              | (32'($urandom_range(0, WORDS - 1)) << OFF_SH)
              | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) access(1'b1, a, $urandom, rd);
            else                           access(1'b0, a, '0, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the single-cycle core's data-memory port and a slower backing memory, and answers core load/store requests with a stall handshake.
- On a read miss it refills a whole line from backing memory over a req/ack handshake.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width; fixed at 32 (4-byte words).
- LINES, 16, number of cache lines; power of two, at least 2.
- WORDS, 4, words per line; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  core access request; held high, with stable addr/we/wdata, until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data; valid while cpu_ready = 1.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_req  out  1  backing-memory request; held until mem_ack.
- mem_we  out  1  backing-memory write enable.
- mem_addr  out  ADDR_W  word-aligned byte address (bits [1:0] = 0).
- mem_wdata  out  DATA_W  backing-memory write data.
- mem_rdata  in  DATA_W  backing-memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle acknowledge; a transfer completes on an edge where mem_req and mem_ack are both 1.
- stat_hits  out  32  read-hit count.
- stat_misses  out  32  read-miss count.

Behaviour:
- Address split, byte addressed:
  - word offset = addr[log2(WORDS)+1:2]
  - line index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage per line: 1 valid bit, tag, WORDS data words.
- States are IDLE, COMPARE, REFILL, WRITE_MEM, DONE. All outputs are registered or decoded from state; there is no combinational path from cpu_* to cpu_ready.
- IDLE:
  - If cpu_req = 1, latch addr, we and wdata, then go to COMPARE.
- COMPARE:
  - hit = valid && tag match.
  - Load hit: load cpu_rdata from the array, then go to DONE.
  - Load miss: clear the refill counter to 0, then go to REFILL.
  - Store: on a hit, write wdata into the cached word this edge. On a miss, leave the array unchanged (no allocate). In both cases go to WRITE_MEM.
- REFILL:
  - mem_req = 1, mem_we = 0, mem_addr = {tag, index, cnt, 2'b00}.
  - On each ack, write mem_rdata into word cnt. If cnt equals the requested offset, also capture it into cpu_rdata.
  - mem_req drops for exactly one cycle between beats.
  - After beat WORDS-1: set valid, write the tag, go to DONE.
  - Words are fetched in order 0..WORDS-1 regardless of the requested offset.
- WRITE_MEM:
  - mem_req = 1, mem_we = 1, mem_addr = latched word address, mem_wdata = latched wdata.
  - On ack, go to DONE.
- DONE:
  - cpu_ready = 1 for this single cycle, then go to IDLE.
  - The core drops or changes cpu_req after the ready edge; IDLE resamples cpu_req.
- Latency from the edge that samples cpu_req:
  - read hit: cpu_ready high during cycle 2.
  - store: 2 cycles + memory wait.
  - read miss: 2 cycles + WORDS beats (each beat = ack wait + 1 gap cycle).
- Reset (async, any state, including mid-refill or mid-write):
  - State → IDLE; every valid bit cleared; refill counter = 0.
  - cpu_ready = 0, cpu_rdata = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - A partially refilled line stays invalid.
- mem_ack while mem_req = 0: ignored.
- A store hit updates the cache before the memory write completes. Loads cannot overlap stores, so this needs no ordering logic.
- Line replacement on refill simply overwrites the line (write-through, so nothing is ever dirty).

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - stat_hits and stat_misses are 32-bit counters, reset to 0.
  - Each increments by 1 on COMPARE of a load hit or a load miss respectively; stores are not counted.
  - Counters wrap from 0xFFFFFFFF to 0.
- Undefined: both ports are driven constant 0 and no counter logic is synthesised.

Test Plan:
- Reset → load 0x00000104, mem returns 0xA0,0xA1,0xA2,0xA3 for words 0x100..0x10C, ack 1 cycle after each req → four beats at mem_addr 0x100,0x104,0x108,0x10C; cpu_ready with cpu_rdata = 0xA1; stat_misses = 1 (with macro).
- Load 0x0000010C right after the previous case → no mem_req; cpu_ready exactly 2 cycles after the sampling edge; cpu_rdata = 0xA3; stat_hits = 1.
- Store 0xDEADBEEF to 0x00000108 (hit), ack after 3 cycles → mem_we = 1, mem_addr = 0x108, mem_wdata = 0xDEADBEEF; a following load of 0x108 hits and returns 0xDEADBEEF.
- Store 0x12345678 to 0x00000900 (miss), then load 0x00000900 → store issues one mem write; the load then misses and refills line 0 (no allocate).
- Load 0x00001104 (same index as 0x104, tag 0x11) → line replaced; a subsequent load of 0x104 misses again.
- Assert rst during the third refill beat → mem_req falls immediately; after release, a load of the same address performs a full 4-beat refill (line invalid).
